sort_sequencer: RTL and testbench



---
 rtl/sort_pkg.sv | 22 ++
 rtl/sort_sequencer_cmp_swap.sv | 18 +
 rtl/sort_sequencer.sv | 128 ++++++++++++
 tb/tb_sort_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types, defaults and schedule arithmetic for the odd-even transposition sorter.
// Latency/backpressure: n/a (package only).
// Optional feature macro used by sort_sequencer: SORT_EARLY_EXIT_EN.
package sort_pkg;

    localparam int W_DEF = 8;
    localparam int N_DEF = 6;

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    function automatic int pairs_in_phase(input int p, input int n);
        return (p % 2 == 0) ? n / 2 : (n - 1) / 2;
    endfunction

    function automatic int total_compares(input int n);
        int c;
        c = 0;
        for (int p = 0; p < n; p++) c += pairs_in_phase(p, n);
        return c;
    endfunction

endpackage

// File: rtl/sort_sequencer_cmp_swap.sv
// Purpose: single compare-exchange; hi gets the larger word, lo the smaller.
// Latency: combinational, zero cycles.
// Backpressure: none; equal words report no swap.
module cmp_swap #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         swapped
);

    assign swapped = (b > a);
    assign hi      = swapped ? b : a;
    assign lo      = swapped ? a : b;

endmodule

// File: rtl/sort_sequencer.sv
// Purpose: serial-load, in-place odd-even transposition sort, descending drain (macro SORT_EARLY_EXIT_EN).
// Latency: total_compares(N) cycles of SORT after the last load (fewer with early exit), then N-word drain.
// Backpressure: in_ready only in LOAD; out_data held stable while out_ready is low.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    // With N=2 the final (odd) phase has no pair, so phase N-2 is effectively the last.
    localparam bit SKIP_ODD_TAIL = (pairs_in_phase(N - 1, N) == 0);

    state_t          state;
    logic [W-1:0]    r [N];
    logic [IW-1:0]   wr_idx, rd_idx, phase, pair, pair_nx;
    logic [IW:0]     pair_p2;
    logic [W-1:0]    cmp_hi, cmp_lo;
    logic            swapped, pair_last, phase_last, early_exit;

    assign pair_nx    = pair + IW'(1);
    assign pair_p2    = {1'b0, pair} + (IW + 1)'(2);
    assign pair_last  = (int'(pair) >= N - 3);
    assign phase_last = (phase == LAST_IDX) || (SKIP_ODD_TAIL && phase == IW'(N - 2));

    cmp_swap #(.W(W)) u_cmp (
        .a       (r[pair]),
        .b       (r[pair_nx]),
        .hi      (cmp_hi),
        .lo      (cmp_lo),
        .swapped (swapped)
    );

`ifdef SORT_EARLY_EXIT_EN
    logic swap_cur, swap_prev, phase_swapped;

    assign phase_swapped = swap_cur | swapped;
    // Two consecutive clean phases (ending on an odd one) mean the array is already ordered.
    assign early_exit    = phase[0] && !phase_swapped && !swap_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_cur  <= 1'b0;
            swap_prev <= 1'b0;
        end else if (state != SORT) begin
            swap_cur  <= 1'b0;
            swap_prev <= 1'b0;
        end else if (pair_last) begin
            swap_prev <= phase_swapped;
            swap_cur  <= 1'b0;
        end else begin
            swap_cur  <= phase_swapped;
        end
    end
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            wr_idx <= '0;
            rd_idx <= '0;
            phase  <= '0;
            pair   <= '0;
            for (int i = 0; i < N; i++) r[i] <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    r[wr_idx] <= in_data;
                    if (wr_idx == LAST_IDX) begin
                        wr_idx <= '0;
                        phase  <= '0;
                        pair   <= '0;
                        state  <= SORT;
                    end else begin
                        wr_idx <= wr_idx + IW'(1);
                    end
                end
                SORT: begin
                    if (swapped) begin
                        r[pair]    <= cmp_hi;
                        r[pair_nx] <= cmp_lo;
                    end
                    if (!pair_last) begin
                        pair <= pair_p2[IW-1:0];
                    end else if (phase_last || early_exit) begin
                        phase <= '0;
                        pair  <= '0;
                        state <= DRAIN;
                    end else begin
                        phase <= phase + IW'(1);
                        pair  <= phase[0] ? '0 : IW'(1);
                    end
                end
                DRAIN: if (out_ready) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_idx <= '0;
                        state  <= LOAD;
                    end else begin
                        rd_idx <= rd_idx + IW'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign busy      = (state == SORT);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? r[rd_idx] : '0;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed and randomised jobs for sort_sequencer, checked against a descending-sort reference.
module tb_sort_sequencer;

    localparam int W = 8;
    localparam int N = 6;

    typedef logic [W-1:0] job_t [N];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_sequencer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain descending selection sort.
    function automatic job_t model_sort(input job_t w);
        job_t s;
        logic [W-1:0] t;
        s = w;
        for (int i = 0; i < N; i++)
            for (int k = i + 1; k < N; k++)
                if (s[k] > s[i]) begin
                    t = s[i]; s[i] = s[k]; s[k] = t;
                end
        return s;
    endfunction

    // Reference SORT duration in cycles from the schedule rules.
    function automatic int model_cycles(input job_t w);
        int c;
`ifdef SORT_EARLY_EXIT_EN
        job_t a;
        logic [W-1:0] t;
        bit prev, cur;
        a = w; c = 0; prev = 0;
        for (int p = 0; p < N; p++) begin
            cur = 0;
            for (int j = p % 2; j + 1 < N; j += 2) begin
                c++;
                if (a[j+1] > a[j]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t; cur = 1;
                end
            end
            if ((p % 2 == 1) && !cur && !prev) return c;
            prev = cur;
        end
        return c;
`else
        c = (w[0] === w[0]) ? 0 : 0;
        for (int p = 0; p < N; p++) c += (p % 2 == 0) ? N / 2 : (N - 1) / 2;
        return c;
`endif
    endfunction

    // Called and returned at a negedge. rmode: 0 ready always, 1 random, 2 stall 4 cycles on word 1.
    task automatic run_job(input job_t w, input int rmode, input bit gaps, input bit hold_in);
        job_t exp;
        int lat_exp, cyc, i, stall, guard;
        exp = model_sort(w);
        lat_exp = model_cycles(w);
        for (int k = 0; k < N; k++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                @(posedge clk); @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[k];
            check("load_in_ready", in_ready, 1);
            @(posedge clk); @(negedge clk);
        end
        in_valid = hold_in;
        in_data  = 8'hEE;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            check("sort_busy", busy, 1);
            check("sort_in_ready", in_ready, 0);
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check("sort_latency", cyc, lat_exp);
        in_valid = 1'b0;
        i = 0; stall = 0; guard = 0;
        while (i < N && guard < 400) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, exp[i]);
            check("drain_last", out_last, (i == N - 1));
            check("drain_busy", busy, 0);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (i == 1 && stall < 4) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            @(posedge clk);
            if (out_ready) i++;
            guard++;
            @(negedge clk);
        end
        check("drain_count", i, N);
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
    endtask

    initial begin
        job_t j;
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t j;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        j = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd200, 8'd0};
        run_job(j, 0, 1'b0, 1'b0);

        j = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        run_job(j, 0, 1'b0, 1'b0);

        j = '{8'd250, 8'd100, 8'd50, 8'd20, 8'd10, 8'd5};
        run_job(j, 0, 1'b0, 1'b0);

        // Output stall on word 1, with in_valid held high through SORT.
        j = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd200, 8'd0};
        run_job(j, 2, 1'b0, 1'b1);

        // Abort mid-SORT after 7 compares.
        j = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = j[k];
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); @(negedge clk);
        end
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        j = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        run_job(j, 0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < N; k++)
                j[k] = (n % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 7));
            run_job(j, 1, 1'b1, n[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
